// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Memory-side responder for the data load/store channel: one request at a time,
// programmable wait, byte-enabled word access. Optional error checking: DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT4     = 4'(LATENCY);
  localparam bit         ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic             we_reg, err_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic [31:0]      rdata_reg;
  logic             resp_err_reg;
  logic [31:0]      mem [DEPTH];

  logic             accept, commit;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             c_we, c_err;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_wdata;
  logic [3:0]       c_be;

  assign req_idx = req_addr[IDX_W+1:2];
`ifdef DMEM_RESP_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
`endif

  assign accept = (state_reg == IDLE) && req_valid;
  // With zero latency the commit happens on the accept edge, straight from the request bus.
  assign commit = (ZERO_LAT && accept) || ((state_reg == WAIT) && (cnt_reg == 4'd1));
  assign c_we    = ZERO_LAT ? req_we    : we_reg;
  assign c_err   = ZERO_LAT ? req_err   : err_reg;
  assign c_idx   = ZERO_LAT ? req_idx   : idx_reg;
  assign c_wdata = ZERO_LAT ? req_wdata : wdata_reg;
  assign c_be    = ZERO_LAT ? req_be    : be_reg;

  always_ff @(posedge clk) begin
    if (rst_n) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) begin
        if (ZERO_LAT) state_next = RESP;
        else          state_next = WAIT;
      end
      WAIT:    if (cnt_reg == 4'd1) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n)                  cnt_reg <= 4'd0;
    else if (accept)            cnt_reg <= LAT4;
    else if (state_reg == WAIT) cnt_reg <= cnt_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      err_reg   <= req_err;
      idx_reg   <= req_idx;
      wdata_reg <= req_wdata;
      be_reg    <= req_be;
    end
  end

  // Reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst_n && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rdata_reg    <= '0;
      resp_err_reg <= 1'b0;
    end else if (commit) begin
      resp_err_reg <= c_err;
      rdata_reg    <= (c_we || c_err) ? 32'd0 : mem[c_idx];
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = resp_err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_responder: a LATENCY=2 instance for directed and random
// transactions and a LATENCY=0 instance for a back-to-back stream, both against a word-array model.
module tb_dmem_responder;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int N_B2B  = 40;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(2)) u_dut_lat2 (
    .clk(clk), .rst_n(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .rst_n(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];

  function automatic bit exp_err(input logic [31:0] addr);
    return ERR_EN && ((addr % 4 != 0) || (addr >= 32'(DEPTH * 4)));
  endfunction

  // Reference: word index is the byte address over 4, modulo DEPTH; stores merge enabled bytes.
  task automatic model_op(input bit use_b, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err);
    int unsigned w;
    logic [31:0] word;
    w     = (addr / 4) % DEPTH;
    word  = use_b ? mdl_b[w] : mdl_a[w];
    err   = exp_err(addr);
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
        if (use_b) mdl_b[w] = word;
        else       mdl_a[w] = word;
      end else begin
        rdata = word;
      end
    end
  endtask

  // Drives one transaction on the LATENCY=2 instance and reports what it observed.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output bit stable, output bit busy_ok, output bit idle_after);
    int n;
    lat = -1; stable = 1'b1; busy_ok = 1'b1; idle_after = 1'b0; rdata = '0; err = 1'b0;
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_req_ready) begin a_req_valid = 1'b0; return; end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_req_we = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom; a_req_be = 4'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_resp_valid) begin lat = k; break; end
      if (a_req_ready) busy_ok = 1'b0;
    end
    if (lat < 0) return;
    rdata = a_resp_rdata; err = a_resp_err;
    if (a_req_ready) busy_ok = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (!a_resp_valid || a_resp_rdata !== rdata || a_resp_err !== err || a_req_ready) stable = 1'b0;
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    @(negedge clk);
    idle_after = a_req_ready && !a_resp_valid;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", a_resp_valid); end
    checks++; if (a_resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", a_resp_rdata); end
    checks++; if (a_resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", a_resp_err); end
    checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_lat0 ready=%b valid=%b exp 1/0", b_req_ready, b_resp_valid); end
  endtask

  task automatic test_basic;
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, bz, ia;
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_store_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL basic_store_resp rdata=%h err=%b exp 0/0", rd, er); end
    checks++; if (!bz || !ia) begin failures++; $display("FAIL basic_store_ready busy_ok=%b idle_after=%b exp 1/1", bz, ia); end
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_load_rdata got=%h exp=deadbeef", rd); end
    checks++; if (lat !== 2 || er !== 1'b0) begin failures++; $display("FAIL basic_load_timing lat=%0d err=%b exp 2/0", lat, er); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, bz, ia;
    txn_a(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
    txn_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
    txn_a(1'b1, 32'h20, 32'h55667788, 4'b0000, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b1, 32'h20, 32'h55667788, 4'b0000, erd, eer);
    checks++; if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin failures++; $display("FAIL be_zero_resp rdata=%h err=%b lat=%0d exp 0/0/2", rd, er, lat); end
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, bz, ia);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_zero_nowrite got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; bit st, bz, ia;
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, bz, ia);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_rdata got=%h exp=deadbeef", rd); end
    checks++; if (!st) begin failures++; $display("FAIL bp_stable got=0 exp=1"); end
    checks++; if (!bz) begin failures++; $display("FAIL bp_req_ready_low got=0 exp=1"); end
    checks++; if (!ia) begin failures++; $display("FAIL bp_idle_after got=0 exp=1"); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd; logic er, eer; int lat, n; bit st, bz, ia, seen;
    txn_a(1'b1, 32'h40, 32'h0, 4'hF, 0, rd, er, lat, st, bz, ia);
    model_op(1'b0, 1'b1, 32'h40, 32'h0, 4'hF, erd, eer);
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, bz, ia);
    a_req_we = 1'b1; a_req_addr = 32'h40; a_req_wdata = 32'hCAFEF00D; a_req_be = 4'hF; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; a_req_valid = 1'b0;
    @(posedge clk); #1; a_rst = 1'b1;
    @(posedge clk); #1; a_rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (a_resp_valid) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL midrst_no_resp got=1 exp=0"); end
    checks++; if (a_req_ready !== 1'b1 || a_resp_rdata !== 32'd0 || a_resp_err !== 1'b0) begin
      failures++; $display("FAIL midrst_state ready=%b rdata=%h err=%b exp 1/0/0", a_req_ready, a_resp_rdata, a_resp_err); end
    txn_a(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, st, bz, ia);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL midrst_no_write got=%h exp=0", rd); end
  endtask

  task automatic test_error;
    logic        we_t    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr_t  [6] = '{32'h0, 32'h1002, 32'h1000, 32'h0, 32'h2, 32'h0};
    logic [31:0] wdata_t [6] = '{32'h12345678, 32'h0, 32'h0BADF00D, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] rd, erd; logic er, eer; int lat; bit st, bz, ia;
    for (int i = 0; i < 6; i++) begin
      txn_a(we_t[i], addr_t[i], wdata_t[i], 4'hF, 0, rd, er, lat, st, bz, ia);
      model_op(1'b0, we_t[i], addr_t[i], wdata_t[i], 4'hF, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin failures++; $display("FAIL err_op%0d rdata=%h err=%b exp %h/%b", i, rd, er, erd, eer); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL err_op%0d_latency got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, addr, wdata; logic er, eer, we; logic [3:0] be; int lat, hold; bit st, bz, ia;
    for (int i = 0; i < 56; i++) begin
      if (i < 16) begin we = 1'b1; addr = 32'(i * 4); be = 4'hF; end
      else begin we = 1'($urandom); addr = 32'($urandom_range(0, 15) * 4); be = 4'($urandom); end
      wdata = $urandom; hold = $urandom_range(0, 2);
      txn_a(we, addr, wdata, be, hold, rd, er, lat, st, bz, ia);
      model_op(1'b0, we, addr, wdata, be, erd, eer);
      checks++; if (rd !== erd || er !== eer) begin failures++; $display("FAIL rand%0d we=%b addr=%h rdata=%h err=%b exp %h/%b", i, we, addr, rd, er, erd, eer); end
      checks++; if (lat !== 2 || !st || !bz || !ia) begin failures++; $display("FAIL rand%0d_handshake lat=%0d stable=%b busy_ok=%b idle=%b exp 2/1/1/1", i, lat, st, bz, ia); end
    end
  endtask

  task automatic next_b_req(input int k);
    if (k < 8) begin b_req_we = 1'b1; b_req_addr = 32'(k * 4); b_req_be = 4'hF; end
    else begin b_req_we = 1'($urandom); b_req_addr = 32'($urandom_range(0, 7) * 4); b_req_be = 4'($urandom); end
    b_req_wdata = $urandom;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd_q [$]; logic exp_er_q [$]; logic [31:0] erd; logic eer;
    int sent, got, last_cyc;
    sent = 0; got = 0; last_cyc = -1;
    b_resp_ready = 1'b1;
    next_b_req(0); b_req_valid = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (b_resp_valid) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_extra_resp cycle=%0d got=resp exp=none", cyc);
        end else begin
          erd = exp_rd_q.pop_front(); eer = exp_er_q.pop_front();
          checks++; if (b_resp_rdata !== erd || b_resp_err !== eer) begin failures++; $display("FAIL b2b_resp%0d rdata=%h err=%b exp %h/%b", got, b_resp_rdata, b_resp_err, erd, eer); end
        end
        checks++; if (b_req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_resp%0d got=%b exp=0", got, b_req_ready); end
        if (got > 0) begin
          checks++; if (cyc - last_cyc != 2) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=2", got, cyc - last_cyc); end
        end
        last_cyc = cyc; got++;
        if (sent < N_B2B) next_b_req(sent);
        else b_req_valid = 1'b0;
      end else if (b_req_ready && b_req_valid) begin
        model_op(1'b1, b_req_we, b_req_addr, b_req_wdata, b_req_be, erd, eer);
        exp_rd_q.push_back(erd); exp_er_q.push_back(eer);
        sent++;
      end
      if (got == N_B2B) break;
      @(negedge clk);
    end
    checks++; if (got != N_B2B) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got, N_B2B); end
    b_resp_ready = 1'b0; b_req_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_resp_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_resp_ready = 1'b0;
    test_reset;
    test_basic;
    test_byte_enable;
    test_backpressure;
    test_reset_mid;
    test_error;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder (memory side) for the core's data-memory load/store channel. It accepts one load/store request at a time over a valid/ready handshake. After a programmable wait it performs a byte-enabled word access on an internal word array. It then returns a response over a second valid/ready handshake. It replaces the zero-latency DMEM when the core runs with a handshaked data bus.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
ADDR_W, 32, request byte-address width
LATENCY, 2, wait cycles inserted between request accept and response valid (0..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on rising clk
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  load data; 0 for stores
resp_err  output  1  access error (see Optional Feature)

Behaviour:
- FSM states: IDLE, WAIT, RESP. req_ready = (state==IDLE). resp_valid = (state==RESP).
- Accept: a rising edge with state==IDLE and req_valid=1. At the accept edge, latch we/addr/wdata/be and load wait counter with LATENCY.
  - LATENCY==0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: counter decrements each edge. The edge where counter==1 is the commit edge; it moves to RESP.
- Commit: performed on the edge entering RESP (the accept edge if LATENCY==0).
  - Store: write enabled bytes only; resp_rdata <= 0.
  - Load: resp_rdata <= full word (be ignored).
- Latency: accept at edge T gives resp_valid high in the cycle after edge T+LATENCY. With LATENCY=0, resp_valid is high the cycle after accept.
- RESP: resp_valid, resp_rdata and resp_err are held stable until the edge with resp_ready=1; that edge returns to IDLE.
  - No request is accepted in the same cycle as response completion. Minimum spacing is LATENCY+2 cycles per transaction.
- req_valid while busy: ignored; the requester must hold it.
- Word index = req_addr[log2(DEPTH)+1:2]. Bits addr[1:0] select nothing; all accesses are word accesses with byte enables.
- Store with req_be=0: no array change; a normal response is still returned.
- Read-after-write: a load accepted after a store response completes returns the new data.
- Reset (rst_n=1 at an edge):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 the following cycle.
  - Array contents are not cleared.
  - Reset mid-transaction drops it. If reset coincides with the commit edge, reset wins and no write occurs.

Optional Feature:
Macro DMEM_RESP_ERR_EN.
- Defined, an access is an error if either:
  - req_addr[1:0]!=0 (misaligned), or
  - req_addr[ADDR_W-1:log2(DEPTH)+2]!=0 (out of range).
- On an error:
  - No array write.
  - resp_rdata=0, resp_err=1.
  - Timing is identical to a normal access.
- Undefined:
  - Upper address bits and addr[1:0] are ignored; the index wraps modulo DEPTH.
  - resp_err is constant 0.

Test Plan:
- Reset, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be=4'hF, accepted at edge T -> resp_valid rises after edge T+2, rdata=0, err=0. A following load of 0x10 -> rdata 0xDEADBEEF.
- Byte-enable merge: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, be=4'b0101 -> subsequent load returns 0x11BB33DD.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stable, req_ready=0 throughout. Raise resp_ready -> IDLE next cycle, req_ready=1.
- LATENCY=0: back-to-back loads with resp_ready=1 -> one response every 2 cycles. req_valid asserted during RESP is not accepted.
- Reset mid-transaction: store to 0x40 (old 0x0) accepted; assert rst_n=1 on the commit edge -> resp_valid never rises, later load of 0x40 returns 0x0.
- DMEM_RESP_ERR_EN, DEPTH=1024: load 0x1002 -> err=1, rdata=0. Store to 0x1000 -> err=1, word 0 unchanged. Without the macro: store to 0x1000 writes word 0, err=0.
